// File: rtl/megasys1_pkg.sv
// Shared types for the ROM port arbiter: FSM states, port indices
// and the default SDRAM word-address width.
package megasys1_pkg;

  localparam int AW_DEFAULT = 23;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  typedef enum logic [1:0] {
    PORT_DL,
    PORT_CPU,
    PORT_GFX0,
    PORT_GFX1
  } port_t;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Request/completion bundle between the ROM port arbiter
// (master) and the SDRAM controller (slave).
interface rom_port_arbiter_if #(
  parameter int AW = megasys1_pkg::AW_DEFAULT
);

  logic          sd_req;
  logic          sd_we;
  logic [AW:1]   sd_addr;
  logic [15:0]   sd_din;
  logic          sd_ack;
  logic [15:0]   sd_dout;

  modport master (
    output sd_req,
    output sd_we,
    output sd_addr,
    output sd_din,
    input  sd_ack,
    input  sd_dout
  );

  modport slave (
    input  sd_req,
    input  sd_we,
    input  sd_addr,
    input  sd_din,
    output sd_ack,
    output sd_dout
  );

endinterface

// File: rtl/rom_byte_packer.sv
// Packs download bytes big-endian into 16-bit words and holds one
// pending write; a word completed while one is still pending is lost.
module rom_byte_packer
  import megasys1_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          download,
  input  logic          wr,
  input  logic [24:0]   addr,
  input  logic [7:0]    data,
  input  logic          wr_done,
  output logic          pend,
  output logic [AW:1]   pend_addr,
  output logic [15:0]   pend_data,
  output logic          overrun
);

  logic [7:0] hi;
  logic       byte_ok;
  logic       word_rdy;
  logic       unused_addr;

  assign byte_ok     = download & wr;
  assign word_rdy    = byte_ok & addr[0];
  assign unused_addr = ^addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      overrun   <= 1'b0;
    end else begin
      if (byte_ok && !addr[0]) begin
        hi <= data;
      end
      // a write acked this very cycle frees the slot for the new word
      if (word_rdy && pend && !wr_done) begin
        overrun <= 1'b1;
      end else if (word_rdy) begin
        pend      <= 1'b1;
        pend_addr <= addr[AW:1];
        pend_data <= {hi, data};
      end else if (wr_done) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one SDRAM request port between ROM download writes, the CPU
// and two graphics fetchers (download > cpu > gfx round-robin).
module rom_port_arbiter
  import megasys1_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          cpu_req,
  input  logic [AW:1]   cpu_addr,
  output logic          cpu_ack,
  output logic [15:0]   cpu_dout,
  input  logic          gfx0_req,
  input  logic [AW:1]   gfx0_addr,
  output logic          gfx0_ack,
  output logic [15:0]   gfx0_dout,
  input  logic          gfx1_req,
  input  logic [AW:1]   gfx1_addr,
  output logic          gfx1_ack,
  output logic [15:0]   gfx1_dout,
  rom_port_arbiter_if.master sd,
  output logic          dl_overrun
);

  state_t      state;
  state_t      state_nx;
  port_t       owner;
  port_t       gnt_port;
  logic        gnt;
  logic        done;
  logic        wr_done;
  logic        pri_g1;
  logic [AW:1] gnt_addr;

  logic        pend;
  logic [AW:1] pend_addr;
  logic [15:0] pend_data;

  logic        rd_ok;
  logic        c_rq;
  logic        g0_rq;
  logic        g1_rq;
  logic        sel_dl;
  logic        sel_cpu;
  logic        sel_g0;
  logic        sel_g1;

  rom_byte_packer #(
    .AW(AW)
  ) u_packer (
    .clk       (clk_sys),
    .reset     (reset),
    .download  (ioctl_download),
    .wr        (ioctl_wr),
    .addr      (ioctl_addr),
    .data      (ioctl_dout),
    .wr_done   (wr_done),
    .pend      (pend),
    .pend_addr (pend_addr),
    .pend_data (pend_data),
    .overrun   (dl_overrun)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (gnt) state_nx = ST_BUSY;
      ST_BUSY: if (sd.sd_ack) state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_ok = ~ioctl_download;
    // a port whose ack is pulsing is still holding its old request
    c_rq  = cpu_req  & ~cpu_ack  & rd_ok;
    g0_rq = gfx0_req & ~gfx0_ack & rd_ok;
    g1_rq = gfx1_req & ~gfx1_ack & rd_ok;

    sel_dl  = pend;
    sel_cpu = ~pend & c_rq;
    sel_g0  = ~pend & ~c_rq & g0_rq & (~g1_rq | ~pri_g1);
    sel_g1  = ~pend & ~c_rq & g1_rq & (~g0_rq | pri_g1);

    gnt      = 1'b0;
    gnt_port = PORT_DL;
    gnt_addr = pend_addr;
    if (state == ST_IDLE) begin
      unique case (1'b1)
        sel_dl: begin
          gnt = 1'b1;
        end
        sel_cpu: begin
          gnt      = 1'b1;
          gnt_port = PORT_CPU;
          gnt_addr = cpu_addr;
        end
        sel_g0: begin
          gnt      = 1'b1;
          gnt_port = PORT_GFX0;
          gnt_addr = gfx0_addr;
        end
        sel_g1: begin
          gnt      = 1'b1;
          gnt_port = PORT_GFX1;
          gnt_addr = gfx1_addr;
        end
        default: ;
      endcase
    end

    done    = (state == ST_BUSY) & sd.sd_ack;
    wr_done = done & (owner == PORT_DL);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      owner      <= PORT_DL;
      pri_g1     <= 1'b0;
      sd.sd_req  <= 1'b0;
      sd.sd_we   <= 1'b0;
      sd.sd_addr <= '0;
      sd.sd_din  <= '0;
      cpu_ack    <= 1'b0;
      gfx0_ack   <= 1'b0;
      gfx1_ack   <= 1'b0;
      cpu_dout   <= '0;
      gfx0_dout  <= '0;
      gfx1_dout  <= '0;
    end else begin
      cpu_ack  <= 1'b0;
      gfx0_ack <= 1'b0;
      gfx1_ack <= 1'b0;
      if (gnt) begin
        owner      <= gnt_port;
        sd.sd_req  <= 1'b1;
        sd.sd_we   <= (gnt_port == PORT_DL);
        sd.sd_addr <= gnt_addr;
        sd.sd_din  <= (gnt_port == PORT_DL) ? pend_data : 16'h0000;
        if (gnt_port == PORT_GFX0) pri_g1 <= 1'b1;
        if (gnt_port == PORT_GFX1) pri_g1 <= 1'b0;
      end else if (done) begin
        sd.sd_req <= 1'b0;
        sd.sd_we  <= 1'b0;
        unique case (owner)
          PORT_CPU: begin
            cpu_ack  <= 1'b1;
            cpu_dout <= sd.sd_dout;
          end
          PORT_GFX0: begin
            gfx0_ack  <= 1'b1;
            gfx0_dout <= sd.sd_dout;
          end
          PORT_GFX1: begin
            gfx1_ack  <= 1'b1;
            gfx1_dout <= sd.sd_dout;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter AW, default 23, meaning SDRAM word-address width (address bits [AW:1]).
REQ-002 clk_sys  input  1  system clock (72 MHz); all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ioctl_download  input  1  ROM download active.
REQ-005 ioctl_wr  input  1  download byte strobe, one cycle.
REQ-006 ioctl_addr  input  25  download byte address.
REQ-007 ioctl_dout  input  8  download byte.
REQ-008 cpu_req, cpu_addr[AW:1]  input  1/AW  CPU read request (level) and word address.
REQ-009 cpu_ack, cpu_dout  output  1/16  CPU one-cycle ack and read data.
REQ-010 gfx0_req/gfx0_addr, gfx1_req/gfx1_addr  input  1/AW each  graphics read requests.
REQ-011 gfx0_ack/gfx0_dout, gfx1_ack/gfx1_dout  output  1/16 each  graphics ack and data.
REQ-012 sd_req, sd_we, sd_addr[AW:1], sd_din  output  1/1/AW/16  request to SDRAM controller.
REQ-013 sd_ack, sd_dout  input  1/16  controller completion pulse and read data.
REQ-014 dl_overrun  output  1  sticky: download byte lost.

Function
REQ-015 Download bytes SHALL be packed big-endian: even ioctl_addr byte -> word[15:8], odd -> word[7:0]; word write queued on odd byte, address ioctl_addr[AW:1].
REQ-016 One-word write buffer; a completed word arriving while the previous write is still unacknowledged SHALL be dropped and dl_overrun set until reset.
REQ-017 FSM states IDLE, BUSY; IDLE->BUSY on grant, BUSY->IDLE on sd_ack.
REQ-018 Priority at grant: pending download write > cpu > gfx0/gfx1 round-robin (last-served gfx port loses ties).
REQ-019 While ioctl_download=1, read requests SHALL NOT be granted; no ack issued.
REQ-020 On grant, sd_req SHALL rise the next cycle and hold with sd_addr/sd_we/sd_din stable until sd_ack.
REQ-021 On sd_ack for a read, the granted port's ack SHALL pulse one cycle after sd_ack with dout = sd_dout captured on sd_ack; other ports' dout unchanged.
REQ-022 Minimum request-to-ack latency SHALL be controller latency + 2 cycles; new grant possible the cycle after return to IDLE.
REQ-023 Requesters hold req until ack; a port SHALL not be re-granted the same request after its ack unless req still high next cycle (treated as new request).
REQ-024 A requester's req dropping while BUSY for it SHALL not abort the SDRAM cycle; ack still pulses.
REQ-025 Simultaneous sd_ack and new byte: write capture and buffer update both occur same cycle.
REQ-026 sd_ack in IDLE SHALL be ignored.

Reset
REQ-027 reset SHALL force: state IDLE, sd_req=0, sd_we=0, sd_addr=0, sd_din=0, all acks 0, all dout=0, dl_overrun=0, write buffer empty, round-robin pointer to gfx0.
REQ-028 reset mid-BUSY SHALL drop sd_req next edge; late sd_ack after reset ignored.

Structure
REQ-029 Shared package megasys1_pkg: state enum, port-index enum (PORT_DL, PORT_CPU, PORT_GFX0, PORT_GFX1), default AW.
REQ-030 One sub-module natural: rom_byte_packer (byte-to-word packing, write buffer, overrun flag).

Verification
REQ-031 Download bytes 0xAB@0x000, 0xCD@0x001 -> one write, sd_addr=0, sd_din=0xABCD, sd_we=1.
REQ-032 cpu_req and gfx0_req same cycle, addr 0x100/0x200 -> cpu served first; gfx0 after cpu_ack; acks one cycle after respective sd_ack.
REQ-033 gfx0 and gfx1 continuously requesting, cpu idle -> grants alternate gfx0, gfx1, gfx0, gfx1.
REQ-034 Second odd byte completed before first write acked -> dl_overrun=1, only first word written.
REQ-035 ioctl_download=1 with cpu_req high -> no grant, cpu_ack stays 0 for 100 cycles; grant within 2 cycles of download end.
REQ-036 reset asserted while BUSY on cpu read -> sd_req=0 next cycle; subsequent sd_ack produces no cpu_ack.
